// File: rtl/display_pkg.sv
// Shared types and constants for the 8-digit seven-segment scan path.
package display_pkg;

  localparam int NUM_DIGITS = 8;
  localparam int SEL_W      = 3;
  localparam logic [NUM_DIGITS-1:0] ANODES_OFF = 8'hFF;

  typedef enum logic [1:0] {
    IDLE,
    SHOW,
    GUARD
  } scan_state_e;

endpackage

// File: rtl/prescale_counter.sv
// Clearable up-counter with terminal-count flag.
// Times both the lit-digit slot and the blanking interval.
module prescale_counter #(
  parameter int W = 17
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic [W-1:0] term,
  output logic         tc
);

  logic [W-1:0] cnt_q, cnt_d;

  assign cnt_d = clr ? '0 : cnt_q + W'(1);
  assign tc    = (cnt_q == term);

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/display_scan_controller.sv
// Digit scan controller for the 8-digit seven-segment display.
// Define GHOST_GUARD_EN to blank all anodes between digits.
module display_scan_controller
  import display_pkg::*;
#(
  parameter int TICK_DIV     = 100000,
  parameter int GUARD_CYCLES = 64,
  parameter int CNT_W        = 17
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [7:0] digit_mask,
  output logic [2:0] sel,
  output logic [7:0] anode,
  output logic       scan_tick,
  output logic       frame_done
);

  localparam logic [NUM_DIGITS-1:0] ONE =
    {{(NUM_DIGITS-1){1'b0}}, 1'b1};

  scan_state_e state_q, state_d;
  logic [SEL_W-1:0]      sel_q, sel_d;
  logic [NUM_DIGITS-1:0] anode_q, anode_d;
  logic tick_q, tick_d;
  logic frame_q, frame_d;
  logic adv;
  logic tc, clr;
  logic [CNT_W-1:0] term;

  assign term = (state_q == GUARD) ? CNT_W'(GUARD_CYCLES - 1)
                                   : CNT_W'(TICK_DIV - 1);
  // Counter restarts on every interval boundary and while parked.
  assign clr  = !enable || (state_q == IDLE) || tc;

  prescale_counter #(
    .W(CNT_W)
  ) u_cnt (
    .clk  (clk),
    .reset(reset),
    .clr  (clr),
    .term (term),
    .tc   (tc)
  );

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    anode_d = ANODES_OFF;
    tick_d  = 1'b0;
    frame_d = 1'b0;
    adv     = 1'b0;
    unique case (state_q)
      IDLE: begin
        state_d = SHOW;
        sel_d   = '0;
      end
      SHOW: begin
        if (tc) begin
`ifdef GHOST_GUARD_EN
          state_d = GUARD;
`else
          adv = 1'b1;
`endif
        end
      end
`ifdef GHOST_GUARD_EN
      GUARD: begin
        if (tc) begin
          adv     = 1'b1;
          state_d = SHOW;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
    if (adv) begin
      sel_d   = sel_q + SEL_W'(1);
      tick_d  = 1'b1;
      frame_d = (sel_q == '1);
    end
    if (state_d == SHOW) begin
      anode_d = ~(digit_mask & (ONE << sel_d));
    end
    if (!enable) begin
      state_d = IDLE;
      sel_d   = '0;
      anode_d = ANODES_OFF;
      tick_d  = 1'b0;
      frame_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      sel_q   <= '0;
      anode_q <= ANODES_OFF;
      tick_q  <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      anode_q <= anode_d;
      tick_q  <= tick_d;
      frame_q <= frame_d;
    end
  end

  assign sel        = sel_q;
  assign anode      = anode_q;
  assign scan_tick  = tick_q;
  assign frame_done = frame_q;

endmodule

// File: tb/tb_display_scan_controller.sv
// Directed bench for display_scan_controller (TICK_DIV=4, GUARD_CYCLES=2).
module tb_display_scan_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [7:0] digit_mask;
  logic [2:0] sel;
  logic [7:0] anode;
  logic       scan_tick;
  logic       frame_done;

  int vecs = 0;
  int errs = 0;

`ifdef GHOST_GUARD_EN
  localparam int NG = 2;
`else
  localparam int NG = 0;
`endif

  display_scan_controller #(
    .TICK_DIV    (4),
    .GUARD_CYCLES(2),
    .CNT_W       (17)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .digit_mask(digit_mask),
    .sel       (sel),
    .anode     (anode),
    .scan_tick (scan_tick),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [2:0] es,
                     input logic [7:0] ea, input logic et,
                     input logic ef);
    @(negedge clk);
    vecs++;
    assert (sel === es && anode === ea &&
            scan_tick === et && frame_done === ef)
    else begin
      errs++;
      $error("FAIL %s: got sel=%0d anode=%h tick=%b fd=%b, want sel=%0d anode=%h tick=%b fd=%b",
             tag, sel, anode, scan_tick, frame_done, es, ea, et, ef);
    end
  endtask

  function automatic logic [7:0] lit(input logic [2:0] s,
                                     input logic [7:0] m);
    logic [7:0] oh;
    oh = 8'b1 << s;
    return m[s] ? ~oh : 8'hFF;
  endfunction

  // One digit slot: 4 lit cycles, then ng blank cycles in guard builds.
  task automatic run_slot(input logic [2:0] s, input bit entry,
                          input int ng);
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("show s%0d c%0d", s, c), s, lit(s, digit_mask),
          (c == 0) && !entry, (c == 0) && !entry && (s == 3'd0));
    end
    for (int g = 0; g < ng; g++) begin
      chk($sformatf("guard s%0d g%0d", s, g), s, 8'hFF, 1'b0, 1'b0);
    end
  endtask

  initial begin
    reset      = 1'b0;
    enable     = 1'b1;
    digit_mask = 8'hFF;

    for (int i = 0; i < 3; i++) chk("reset", 3'd0, 8'hFF, 1'b0, 1'b0);
    reset = 1'b1;

    // Two full frames plus the first slot of the third.
    run_slot(3'd0, 1'b1, NG);
    for (int s = 1; s <= 16; s++) run_slot(3'(s), 1'b0, NG);

    digit_mask = 8'h0F;
    for (int s = 17; s <= 24; s++) run_slot(3'(s), 1'b0, NG);

    digit_mask = 8'hFF;
    for (int s = 25; s <= 28; s++) run_slot(3'(s), 1'b0, NG);
    chk("sel5 c0", 3'd5, 8'hDF, 1'b1, 1'b0);
    chk("sel5 c1", 3'd5, 8'hDF, 1'b0, 1'b0);
    enable = 1'b0;
    chk("disable", 3'd0, 8'hFF, 1'b0, 1'b0);
    chk("parked", 3'd0, 8'hFF, 1'b0, 1'b0);
    enable = 1'b1;
    run_slot(3'd0, 1'b1, NG);
    run_slot(3'd1, 1'b0, NG);

    // Reset lands mid-blank in guard builds, mid-slot otherwise.
    run_slot(3'd2, 1'b0, (NG > 0) ? 1 : 0);
`ifndef GHOST_GUARD_EN
    chk("pre-rst c0", 3'd3, 8'hF7, 1'b1, 1'b0);
`endif
    reset = 1'b0;
    chk("mid reset", 3'd0, 8'hFF, 1'b0, 1'b0);
    chk("hold reset", 3'd0, 8'hFF, 1'b0, 1'b0);
    reset = 1'b1;
    run_slot(3'd0, 1'b1, NG);
    run_slot(3'd1, 1'b0, NG);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/display_scan_controller.md
Name: display_scan_controller

Overview:
Time-multiplexing scan controller for the 8-digit seven-segment display. Generates the 3-bit digit select that drives the 8-to-1 nibble mux feeding the hex-to-7-segment decoder, and the matching active-low anode enables. Refresh rate is set by a prescaler, and an optional ghost-guard interval blanks all anodes between digits. Sits between the board clock and the display datapath; the mux and decoder stay combinational downstream.

Parameters:
TICK_DIV, 100000, clk cycles each digit is lit (min 2); 100 MHz gives 1 kHz per digit.
GUARD_CYCLES, 64, clk cycles all anodes are off between digits (min 1); used only with GHOST_GUARD_EN.
CNT_W, 17, prescale counter width; must satisfy 2^CNT_W >= max(TICK_DIV, GUARD_CYCLES).

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  synchronous, active-low reset.
enable  input  1  1 = scan; 0 = display dark, scan parked.
digit_mask  input  8  bit i = 1 lets digit i light; 0 keeps anode i off while its slot still elapses.
sel  output  3  digit index to the nibble mux (0..7).
anode  output  8  active-low anode enables; at most one bit low.
scan_tick  output  1  one-cycle pulse in the cycle after sel changes.
frame_done  output  1  one-cycle pulse in the cycle after sel wraps 7->0.

Behaviour:
- One clock; reset is synchronous and active-low.
- All outputs are registered.
- Reset (reset==0 at an edge): state=IDLE, cnt=0, sel=0, anode=8'hFF, scan_tick=0, frame_done=0. Reset overrides every other input.
- States: IDLE, SHOW, GUARD (GUARD exists only with GHOST_GUARD_EN).
- IDLE: anode=FF, sel=0, cnt=0.
  - Edge with enable=1 -> SHOW, cnt=0, sel=0, anode=~({7'b0,digit_mask[0]}).
  - No scan_tick is generated on this entry.
- SHOW: cnt increments each edge, so sel is held exactly TICK_DIV cycles.
  - anode[i] = ~(i==sel && digit_mask[i]), re-registered every edge; a mask change appears 1 cycle later.
  - Edge with cnt==TICK_DIV-1: end of slot (see the optional feature for the transition).
- Advance: sel <= sel+1, wrapping modulo 8 (7->0).
  - scan_tick=1 for exactly the next cycle.
  - frame_done=1 for exactly the next cycle when the advance is a 7->0 wrap.
- enable=0 at any edge in any state -> IDLE next cycle: anode=FF, sel=0, cnt=0, no pulses. Re-enable restarts at digit 0.
- digit_mask=00: scan timing, sel and pulses are unchanged; anode stays FF.
- Invariant: anode is never more than one-hot-low; a pulse never lasts more than 1 cycle.

Optional Feature:
Macro: GHOST_GUARD_EN.
- Defined:
  - At the end of a SHOW slot -> GUARD with anode=FF, cnt=0; sel is held.
  - GUARD lasts GUARD_CYCLES cycles.
  - At its last edge: advance sel, -> SHOW, cnt=0, anode for the new sel, same edge.
  - Full frame = 8*(TICK_DIV+GUARD_CYCLES) cycles.
- Undefined:
  - GUARD state and GUARD_CYCLES are unused.
  - At the end of a SHOW slot: advance sel, stay in SHOW, cnt=0, new anode on the same edge.
  - Frame = 8*TICK_DIV cycles.

Decomposition:
- Shared package display_pkg:
  - scan state enum (IDLE, SHOW, GUARD).
  - localparam ANODES_OFF = 8'hFF.
  - localparam NUM_DIGITS = 8.
  - localparam SEL_W = 3.
- One natural sub-module: prescale_counter.
  - Loadable up-counter; inputs clr and terminal value; output is a terminal-count flag.
  - Same reset convention as the parent.
  - Reused for the SHOW and GUARD intervals.

Test Plan:
Bench config for all scenarios: TICK_DIV=4, GUARD_CYCLES=2, digit_mask=FF unless stated.
1. Reset held 3 cycles with enable=1 -> sel=0, anode=FF, no pulses. After release: anode=FE one cycle later, sel=0 held 4 cycles, then sel=1, anode=FD, scan_tick high 1 cycle.
2. Free-run 2 frames, guard off -> sel steps 0..7 every 4 cycles. frame_done pulses every 32 cycles, in the cycle after sel 7->0. anode always one-hot-low matching sel.
3. GHOST_GUARD_EN defined -> after each 4-cycle SHOW, anode=FF for 2 cycles with sel held; frame_done period is 48 cycles.
4. digit_mask=8'h0F -> digits 4..7 leave anode=FF while sel still visits 4..7; timing is identical to scenario 2.
5. enable dropped while sel=5, mid-slot -> next cycle anode=FF, sel=0, no scan_tick. Re-enable -> anode=FE after 1 cycle, fresh full 4-cycle slot.
6. reset asserted mid-GUARD (guard build) -> next cycle all outputs at their reset values. Release with enable=1 -> sequence restarts exactly as in scenario 1.
